instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage that sits directly upstream of the operational memory's fetch port. It owns the program counter and issues word reads on `fetchAddress`/`fetchEnable`, capturing the 32-bit `fetchOutput` one cycle later. It delivers `{pc, instruction}` pairs to decode over a valid/ready handshake, buffering in-flight words in a 2-entry queue. Redirects from branches, jumps and traps flush all queued and in-flight work.

## Interface
- `RESET_PC`, 16'h0000: word address fetched first after reset.
- `ADDR_W`, 16: PC / fetch address width, matching the memory fetch port.
- `DATA_W`, 32: instruction width, matching `fetchOutput`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fetchAddress`  out  ADDR_W  word address to the memory fetch port.
- `fetchEnable`  out  1  read strobe; data is valid on `fetchOutput` the next cycle.
- `fetchOutput`  in  DATA_W  read data from the memory, 1-cycle latency.
- `redirect_valid`  in  1  flush and restart at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `fetch_halt`  in  1  suppresses new requests; an in-flight read still completes.
- `out_valid`  out  1  an instruction is presented to decode.
- `out_ready`  in  1  decode accepts the instruction.
- `out_instr`  out  DATA_W  instruction word.
- `out_pc`  out  ADDR_W  word address of `out_instr`.

## Operation
- **State:**
  - `pc`: next address to request.
  - `inflight`: a request was issued last cycle.
  - `inflight_pc`: address of that request.
  - `squash`: the in-flight result must be dropped.
  - 2-entry FIFO of `{pc, instr}` with `count` 0..2.
- **Reset** (`rst_n`=0 at the edge):
  - `pc` <= RESET_PC; `count`, `inflight`, `squash` <= 0.
  - Outputs during reset: `fetchEnable`=0, `fetchAddress`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0.
- **Pop:** `pop = out_valid && out_ready`. `out_valid = (count != 0) && !redirect_valid`.
- **Issue (no redirect):**
  - Issue when `!fetch_halt && (count - pop + inflight) < 2`.
  - On issue: `fetchAddress=pc`, `fetchEnable=1`, `pc <= pc+1`. The increment wraps mod 2^ADDR_W, so FFFF is followed by 0000.
- **Return:**
  - If `inflight && !squash`, push `{inflight_pc, fetchOutput}` into the FIFO.
  - Push and pop in the same cycle are legal in any state.
  - The issue rule guarantees a push never overflows.
- **Redirect** (`redirect_valid`=1, highest priority, overrides `fetch_halt`):
  - FIFO is cleared. Any return arriving this cycle is discarded.
  - `fetchAddress=redirect_pc`, `fetchEnable=1`, `inflight_pc<=redirect_pc`, `pc <= redirect_pc+1`, `squash<=0`.
  - No pop occurs that cycle.
- **Bank switches:**
  - Any `operationMode` change at the memory is asserted in the same cycle as a redirect.
  - The old-bank in-flight word is therefore always discarded.
  - The block has no mode input.
- **Halt:** outstanding FIFO entries keep draining; `pc` holds.

## Timing
- First request in the first cycle after `rst_n` rises. First `out_valid` two cycles after that request.
- Issue-to-`out_valid` latency is 2 cycles. Redirect-to-`out_valid` latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle while `out_ready`=1. Steady state is `count`=1 with one read in flight.
- **Decode stalls:** `out_ready`=0 for N cycles leaves at most 2 words buffered and 0 in flight. Issue resumes in the same cycle `out_ready` returns high.
- `out_instr`/`out_pc` hold stable while `out_valid && !out_ready`.
- **Reset mid-operation:** in-flight data returning in the cycle after reset is discarded, because `inflight` has been cleared.

## Structure
- Shared package `fetch_pkg`: `addr_t` (ADDR_W), `instr_t` (DATA_W), `fetch_entry_t` = `{addr_t pc; instr_t instr}`, and the default RESET_PC constant.
- Sub-module `fetch_skid_fifo`: 2-entry synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, clear, count, head.
  - Synchronous active-low reset.
  - Clear has priority over push.
- Top level holds the PC, the issue/credit logic and the redirect/squash control.

## Test plan
- **Reset, streaming:** memory returns addr+0x1000 per address, `out_ready`=1. Requests 0,1,2,... start the cycle after reset. `out_valid` rises 2 cycles later with `out_pc`=0, `out_instr`=0x1000, then one word per cycle.
- **Backpressure:** `out_ready`=0 for 5 cycles after pc 3 is presented. Exactly pcs 3,4 are buffered and no `fetchEnable` fires during the stall. On release, 3,4,5 are delivered with no gaps or duplicates.
- **Redirect:** redirect to 0x0040 while 2 entries are queued and 1 read is in flight. Next cycle `out_valid`=0, and the following cycle `out_pc`=0x0040. No stale pc is ever delivered.
- **Redirect + stall:** simultaneous redirect, `out_ready`=1 and a returning word. No pop is counted and the returning word is dropped.
- **Wrap-around:** redirect to 0xFFFE delivers pcs FFFE, FFFF, 0000, 0001 in order.
- **Halt and reset:** `fetch_halt` mid-stream makes `fetchEnable` drop the next cycle while buffered words still drain. Asserting `rst_n`=0 with a read in flight yields `out_valid`=0 for the cycle after release, then a restart at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: address/instruction words,
// the {pc, instr} queue entry and the default reset PC.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 32;
    localparam int FIFO_DEPTH   = 2;

    typedef logic [FETCH_ADDR_W-1:0] addr_t;
    typedef logic [FETCH_DATA_W-1:0] instr_t;
    typedef logic [1:0]              count_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

    localparam addr_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry synchronous FIFO of {pc, instr} pairs between the memory return
// path and decode. Clear wins over push.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_clear,
    output count_t       o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [FIFO_DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    count_t       r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + count_t'(i_push) - count_t'(i_pop);
        end
    end

    // NOTE: the storage array is deliberately not reset; r_count alone says
    // which slots hold live data.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word reads to the memory fetch port and
// hands {pc, instr} pairs to decode over valid/ready, flushing on redirect.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    ADDR_W   = FETCH_ADDR_W,
    parameter int    DATA_W   = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] fetchAddress,
    output logic              fetchEnable,
    input  logic [DATA_W-1:0] fetchOutput,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              fetch_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inflight_pc;
    logic              r_inflight;
    logic              r_squash;

    count_t            w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic [2:0]        w_credit;

    // Words queued after this cycle's pop plus the one in flight must leave
    // room for the read about to be issued.
    assign w_credit = {1'b0, w_count} - 3'(w_pop) + 3'(r_inflight);
    assign w_issue  = !fetch_halt && (w_credit < 3'd2);

    assign out_valid = rst_n && (w_count != '0) && !redirect_valid;
    assign w_pop     = out_valid && out_ready;
    assign out_pc    = rst_n ? w_head.pc    : '0;
    assign out_instr = rst_n ? w_head.instr : '0;

    assign w_push       = r_inflight && !r_squash;
    assign w_push_entry = '{pc: r_inflight_pc, instr: fetchOutput};

    // NOTE: every combinational output gets a default first so no path
    // through the if/else chain can infer a latch.
    always_comb begin
        fetchEnable  = 1'b0;
        fetchAddress = r_pc;
        if (!rst_n) begin
            fetchAddress = RESET_PC;
        end else if (redirect_valid) begin
            fetchEnable  = 1'b1;
            fetchAddress = redirect_pc;
        end else if (w_issue) begin
            fetchEnable  = 1'b1;
        end
    end

    // A redirect restarts the in-flight slot at redirect_pc and the FIFO
    // clear drops the stale return, so squash only ever returns to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= RESET_PC;
            r_squash      <= 1'b0;
        end else if (redirect_valid) begin
            r_pc          <= redirect_pc + 1'b1;
            r_inflight    <= 1'b1;
            r_inflight_pc <= redirect_pc;
            r_squash      <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
                r_pc          <= r_pc + 1'b1;
            end
        end
    end

    fetch_skid_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_clear     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model returns addr+0x1000 one
// cycle after each read; accepted words are checked against a pc queue.
module tb_instruction_fetch;
    import fetch_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    addr_t  fetchAddress;
    logic   fetchEnable;
    instr_t fetchOutput;
    logic   redirect_valid;
    addr_t  redirect_pc;
    logic   fetch_halt;
    logic   out_valid;
    logic   out_ready;
    instr_t out_instr;
    addr_t  out_pc;

    fetch_entry_t exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetchAddress   (fetchAddress),
        .fetchEnable    (fetchEnable),
        .fetchOutput    (fetchOutput),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_halt     (fetch_halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    function automatic instr_t mem_word(input addr_t a);
        return 32'(a) + 32'h0000_1000;
    endfunction

    // Memory fetch port: one-cycle read latency, junk when not enabled.
    always @(posedge clk) begin
        fetchOutput <= fetchEnable ? mem_word(fetchAddress) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_range(input addr_t start, input int n);
        addr_t a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: a, instr: mem_word(a)});
            a = a + 1'b1;
        end
    endtask

    // Score any accepted word, then advance one clock.
    task automatic cyc();
        fetch_entry_t e;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", {16'h0, out_pc}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("deliver_pc", {16'h0, out_pc}, {16'h0, e.pc});
                chk("deliver_instr", out_instr, e.instr);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fetch_halt     = 1'b0;
        out_ready      = 1'b1;
        cyc();
        cyc();

        // Reset outputs
        #1;
        chk("rst_fetchEnable", 32'(fetchEnable), 32'd0);
        chk("rst_fetchAddress", 32'(fetchAddress), 32'h0000);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        cyc();

        // Streaming from RESET_PC
        rst_n = 1'b1;
        expect_range(16'h0000, 7);
        #1;
        chk("first_req_en", 32'(fetchEnable), 32'd1);
        chk("first_req_addr", 32'(fetchAddress), 32'h0000);
        chk("first_req_valid", 32'(out_valid), 32'd0);
        cyc();
        #1;
        chk("second_req_addr", 32'(fetchAddress), 32'h0001);
        chk("second_req_valid", 32'(out_valid), 32'd0);
        cyc();
        #1;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_pc", 32'(out_pc), 32'h0000);
        chk("first_instr", out_instr, 32'h0000_1000);
        cyc();
        cyc();
        cyc();

        // Backpressure with pc 3 presented
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", 32'(out_pc), 32'h0003);
            chk("stall_no_fetch", 32'(fetchEnable), 32'd0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("release_fetch_en", 32'(fetchEnable), 32'd1);
        chk("release_fetch_addr", 32'(fetchAddress), 32'h0005);
        chk("release_pc", 32'(out_pc), 32'h0003);
        cyc();
        cyc();
        cyc();
        cyc();

        // Fill both entries (pcs 7, 8), then redirect to 0x0040
        out_ready = 1'b0;
        #1;
        chk("prefill_pc", 32'(out_pc), 32'h0007);
        cyc();
        cyc();
        cyc();
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        expect_range(16'h0040, 3);
        #1;
        chk("redir_valid_low", 32'(out_valid), 32'd0);
        chk("redir_fetch_en", 32'(fetchEnable), 32'd1);
        chk("redir_fetch_addr", 32'(fetchAddress), 32'h0040);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("redir_next_valid", 32'(out_valid), 32'd0);
        chk("redir_next_addr", 32'(fetchAddress), 32'h0041);
        cyc();
        #1;
        chk("redir_target_valid", 32'(out_valid), 32'd1);
        chk("redir_target_pc", 32'(out_pc), 32'h0040);
        cyc();
        cyc();
        cyc();

        // Redirect with ready high while 0x43 is queued and 0x44 returns
        #1;
        chk("pre_redir2_pc", 32'(out_pc), 32'h0043);
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        expect_range(16'hFFFE, 5);
        #1;
        chk("redir2_valid_low", 32'(out_valid), 32'd0);
        chk("redir2_fetch_addr", 32'(fetchAddress), 32'hFFFE);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("redir2_return_dropped", 32'(out_valid), 32'd0);
        chk("wrap_next_addr", 32'(fetchAddress), 32'hFFFF);
        cyc();
        #1;
        chk("wrap_first_pc", 32'(out_pc), 32'hFFFE);
        cyc();
        #1;
        chk("wrap_fetch_addr", 32'(fetchAddress), 32'h0001);
        cyc();
        cyc();

        // Halt while pc 0001 is presented and 0002 is in flight
        fetch_halt = 1'b1;
        #1;
        chk("halt_pc", 32'(out_pc), 32'h0001);
        chk("halt_no_fetch", 32'(fetchEnable), 32'd0);
        cyc();
        #1;
        chk("halt_drain_valid", 32'(out_valid), 32'd1);
        chk("halt_no_fetch2", 32'(fetchEnable), 32'd0);
        cyc();
        #1;
        chk("halt_empty", 32'(out_valid), 32'd0);
        chk("halt_no_fetch3", 32'(fetchEnable), 32'd0);
        cyc();
        fetch_halt = 1'b0;
        #1;
        chk("unhalt_fetch_en", 32'(fetchEnable), 32'd1);
        chk("unhalt_pc_held", 32'(fetchAddress), 32'h0003);
        cyc();

        // Reset with read of 0003 in flight
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_fetch_en", 32'(fetchEnable), 32'd0);
        cyc();
        rst_n = 1'b1;
        expect_range(16'h0000, 3);
        #1;
        chk("postrst_valid", 32'(out_valid), 32'd0);
        chk("postrst_fetch_addr", 32'(fetchAddress), 32'h0000);
        chk("postrst_fetch_en", 32'(fetchEnable), 32'd1);
        cyc();
        #1;
        chk("postrst_valid2", 32'(out_valid), 32'd0);
        cyc();
        #1;
        chk("restart_pc", 32'(out_pc), 32'h0000);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            cyc();
        end
        out_ready = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
